rr_arbiter3: RTL

//  Round-robin arbiter granting one shared gate-level datapath (ALU / result bus) to

---
 rtl/rr_arbiter3_pkg.sv | 18 +
 rtl/or3_cell.sv | 11 +
 rtl/rr_pick3.sv | 46 ++++
 rtl/rr_arbiter3.sv | 80 ++++++++
 4 files changed

// File: rtl/rr_arbiter3_pkg.sv
// rtl/rr_arbiter3_pkg.sv - shared types and constants for the three-way round-robin arbiter
package rr_arbiter3_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } arb_state_t;

   localparam int NREQ         = 3;
   localparam int DEF_MAX_HOLD = 15;
   localparam int DEF_CNT_W    = 4;

   // Rotate a requester index 0 -> 1 -> 2 -> 0.
   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/or3_cell.sv
// rtl/or3_cell.sv - three-input OR gate cell
module or3_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);

   assign y = a | b | c;

endmodule

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational round-robin pick among three requests
module rr_pick3 (
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] sel,
   output logic       sel_valid
);

   logic [1:0] o0, o1, o2;

   // Search order starts at ptr; an out-of-range ptr behaves like 0.
   always_comb begin
      o0 = 2'd0;
      o1 = 2'd1;
      o2 = 2'd2;
      case (ptr)
         2'd1: begin
            o0 = 2'd1;
            o1 = 2'd2;
            o2 = 2'd0;
         end
         2'd2: begin
            o0 = 2'd2;
            o1 = 2'd0;
            o2 = 2'd1;
         end
         default: ;
      endcase
   end

   always_comb begin
      sel       = 2'd0;
      sel_valid = 1'b0;
      if (req[o0]) begin
         sel       = o0;
         sel_valid = 1'b1;
      end else if (req[o1]) begin
         sel       = o1;
         sel_valid = 1'b1;
      end else if (req[o2]) begin
         sel       = o2;
         sel_valid = 1'b1;
      end
   end

endmodule

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - registered one-hot round-robin arbiter with hold-time limit
module rr_arbiter3
   import rr_arbiter3_pkg::*;
#(
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic            grant_valid,
   output logic [1:0]      grant_id,
   output logic            timeout
);

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

   arb_state_t       state;
   logic [1:0]       ptr;
   logic [CNT_W-1:0] hold_cnt;
   logic             any_req;
   logic [1:0]       sel;
   logic             sel_valid;

   or3_cell u_any_req (
      .a (req[0]),
      .b (req[1]),
      .c (req[2]),
      .y (any_req)
   );

   rr_pick3 u_pick (
      .req       (req),
      .ptr       (ptr),
      .sel       (sel),
      .sel_valid (sel_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         ptr         <= 2'd0;
         hold_cnt    <= '0;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_id    <= 2'd0;
         timeout     <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_req && sel_valid) begin
                  grant       <= 3'b001 << sel;
                  grant_id    <= sel;
                  grant_valid <= 1'b1;
                  hold_cnt    <= CNT_W'(1);
                  state       <= S_GRANT;
               end
            end
            S_GRANT: begin
               // Release on owner drop or hold limit; the owner moves to lowest priority.
               if (!req[grant_id] || hold_cnt == HOLD_LIM) begin
                  grant       <= '0;
                  grant_valid <= 1'b0;
                  grant_id    <= 2'd0;
                  hold_cnt    <= '0;
                  ptr         <= next_idx(grant_id);
                  timeout     <= req[grant_id];
                  state       <= S_IDLE;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
